ram512_arbiter: RTL and testbench

RAM512_ARBITER -- requirements
Module: ram512_arbiter

---
 rtl/ram512_arbiter.sv | 131 +++++++++++++
 tb/tb_ram512_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram512_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM512.
// An optional zero-fill sweep runs after reset and can be restarted with clr_start.
module ram512_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [8:0]  addr0,
    input  logic [8:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    input  logic        clr_start,
    output logic        init_done,
    output logic [15:0] ram_in,
    output logic        ram_load,
    output logic [8:0]  ram_address,
    input  logic [15:0] ram_out
);

    typedef enum logic {
        CLEAR,
        SERVE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  clr_ptr;
    logic [8:0]  clr_ptr_next;
    logic        last_gnt;
    logic        last_gnt_next;
    logic        gnt0_int;
    logic        gnt1_int;
    logic        ram_load_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR_ON_RESET ? CLEAR : SERVE;
            clr_ptr  <= 9'd0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_next;
            clr_ptr  <= clr_ptr_next;
            last_gnt <= last_gnt_next;
        end
    end

    // clr_start takes priority over arbitration: that cycle grants nothing.
    always_comb begin
        state_next    = state;
        clr_ptr_next  = clr_ptr;
        last_gnt_next = last_gnt;
        gnt0_int      = 1'b0;
        gnt1_int      = 1'b0;
        ram_load_int  = 1'b0;
        ram_address   = 9'd0;
        ram_in        = 16'd0;
        case (state)
            CLEAR: begin
                ram_load_int = 1'b1;
                ram_address  = clr_ptr;
                if (clr_ptr == 9'd511) begin
                    state_next   = SERVE;
                    clr_ptr_next = 9'd0;
                end else begin
                    clr_ptr_next = clr_ptr + 9'd1;
                end
            end
            SERVE: begin
                if (clr_start) begin
                    state_next   = CLEAR;
                    clr_ptr_next = 9'd0;
                end else begin
                    if (req0 && (!req1 || last_gnt)) begin
                        gnt0_int = 1'b1;
                    end else if (req1) begin
                        gnt1_int = 1'b1;
                    end
                    if (gnt0_int) begin
                        ram_address   = addr0;
                        ram_in        = wdata0;
                        ram_load_int  = we0;
                        last_gnt_next = 1'b0;
                    end else if (gnt1_int) begin
                        ram_address   = addr1;
                        ram_in        = wdata1;
                        ram_load_int  = we1;
                        last_gnt_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Reset gates the strobes directly so nothing is written or granted while rst_n is low.
    assign gnt0      = gnt0_int & rst_n;
    assign gnt1      = gnt1_int & rst_n;
    assign ram_load  = ram_load_int & rst_n;
    assign init_done = (state == SERVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= 16'd0;
            rdata1  <= 16'd0;
        end else begin
            rvalid0 <= gnt0_int & ~we0;
            rvalid1 <= gnt1_int & ~we1;
            if (gnt0_int && !we0) begin
                rdata0 <= ram_out;
            end
            if (gnt1_int && !we1) begin
                rdata1 <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed bench for ram512_arbiter with a behavioural RAM512 attached.
module tb_ram512_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        clr_start;
    logic        init_done;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [8:0]  ram_address;
    logic [15:0] ram_out;

    int n_checks;
    int n_fails;

    logic [15:0] mem [512];

    ram512_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .clr_start  (clr_start),
        .init_done  (init_done),
        .ram_in     (ram_in),
        .ram_load   (ram_load),
        .ram_address(ram_address),
        .ram_out    (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
    end
    assign ram_out = mem[ram_address];

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
                                 input logic r1, input logic w1, input logic [8:0] a1, input logic [15:0] d1,
                                 input logic cs);
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        clr_start = cs;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 512; i++) mem[i] = 16'hA5A5;
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'd0; wdata0 = 16'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'd0; wdata1 = 16'd0;
        clr_start = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("rst_gnt0", gnt0, 0);
        checkOutput("rst_gnt1", gnt1, 0);
        checkOutput("rst_load", ram_load, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_rvalid0", rvalid0, 0);
        checkOutput("rst_rdata1", rdata1, 0);

        // Power-up fill: addresses 0..511 with load high, requests ignored
        for (int i = 0; i < 512; i++) begin
            applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
            if (i == 0) rst_n = 1'b1;
            #1;
            checkOutput("clr_addr", ram_address, 16'(i));
            checkOutput("clr_load", ram_load, 1);
            checkOutput("clr_in", ram_in, 16'h0000);
            checkOutput("clr_init_done", init_done, 0);
        end
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("serve_init_done", init_done, 1);
        checkOutput("idle_load", ram_load, 0);
        checkOutput("idle_addr", ram_address, 16'h0000);

        applyStimulus(1, 0, 9'h1FF, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rd1ff_gnt0", gnt0, 1);
        checkOutput("rd1ff_addr", ram_address, 16'h01FF);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rd1ff_rvalid0", rvalid0, 1);
        checkOutput("rd1ff_rdata0", rdata0, 16'h0000);
        checkOutput("rd1ff_rvalid1", rvalid1, 0);

        // Port 0 write 0xDEAD to 0x02A then read back
        applyStimulus(1, 1, 9'h02A, 16'hDEAD, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("wr2a_gnt0", gnt0, 1);
        checkOutput("wr2a_load", ram_load, 1);
        checkOutput("wr2a_addr", ram_address, 16'h002A);
        checkOutput("wr2a_in", ram_in, 16'hDEAD);
        applyStimulus(1, 0, 9'h02A, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rd2a_gnt0", gnt0, 1);
        checkOutput("rd2a_load", ram_load, 0);
        checkOutput("wr2a_no_rvalid", rvalid0, 0);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rd2a_rvalid0", rvalid0, 1);
        checkOutput("rd2a_rdata0", rdata0, 16'hDEAD);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rd2a_rvalid0_drop", rvalid0, 0);
        checkOutput("rd2a_rdata0_hold", rdata0, 16'hDEAD);

        // Preload, then both ports read continuously for 4 cycles
        applyStimulus(1, 1, 9'h010, 16'h1111, 0, 0, 9'd0, 16'd0, 0);
        applyStimulus(0, 0, 9'd0, 16'd0, 1, 1, 9'h011, 16'h2222, 0);
        checkOutput("pre_gnt1", gnt1, 1);
        applyStimulus(1, 0, 9'h010, 16'd0, 1, 0, 9'h011, 16'd0, 0);
        checkOutput("rr1_gnt0", gnt0, 1);
        checkOutput("rr1_gnt1", gnt1, 0);
        applyStimulus(1, 0, 9'h010, 16'd0, 1, 0, 9'h011, 16'd0, 0);
        checkOutput("rr2_gnt1", gnt1, 1);
        checkOutput("rr2_gnt0", gnt0, 0);
        checkOutput("rr2_rvalid0", rvalid0, 1);
        checkOutput("rr2_rdata0", rdata0, 16'h1111);
        checkOutput("rr2_rvalid1", rvalid1, 0);
        applyStimulus(1, 0, 9'h010, 16'd0, 1, 0, 9'h011, 16'd0, 0);
        checkOutput("rr3_gnt0", gnt0, 1);
        checkOutput("rr3_rvalid1", rvalid1, 1);
        checkOutput("rr3_rdata1", rdata1, 16'h2222);
        checkOutput("rr3_rvalid0", rvalid0, 0);
        applyStimulus(1, 0, 9'h010, 16'd0, 1, 0, 9'h011, 16'd0, 0);
        checkOutput("rr4_gnt1", gnt1, 1);
        checkOutput("rr4_rvalid0", rvalid0, 1);
        checkOutput("rr4_rdata0", rdata0, 16'h1111);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("rr5_rvalid1", rvalid1, 1);
        checkOutput("rr5_rdata1", rdata1, 16'h2222);

        // Make last_gnt=0, then port 1 write races port 0 read of 0x100
        applyStimulus(1, 1, 9'h100, 16'h1234, 0, 0, 9'd0, 16'd0, 0);
        applyStimulus(1, 0, 9'h100, 16'd0, 1, 1, 9'h100, 16'hBEEF, 0);
        checkOutput("race_gnt1", gnt1, 1);
        checkOutput("race_gnt0", gnt0, 0);
        checkOutput("race_in", ram_in, 16'hBEEF);
        checkOutput("race_load", ram_load, 1);
        applyStimulus(1, 0, 9'h100, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("race_rd_gnt0", gnt0, 1);
        checkOutput("race_rd_addr", ram_address, 16'h0100);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("race_rvalid0", rvalid0, 1);
        checkOutput("race_rdata0", rdata0, 16'hBEEF);
        checkOutput("race_rvalid1", rvalid1, 0);

        // clr_start beats a pending read; second clr_start mid-fill is ignored
        applyStimulus(1, 0, 9'h02A, 16'd0, 0, 0, 9'd0, 16'd0, 1);
        checkOutput("clrs_gnt0", gnt0, 0);
        checkOutput("clrs_load", ram_load, 0);
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1, 0, 9'h02A, 16'd0, 0, 0, 9'd0, 16'd0, (i == 100));
            checkOutput("clr2_addr", ram_address, 16'(i));
            checkOutput("clr2_gnt0", gnt0, 0);
            checkOutput("clr2_init_done", init_done, 0);
        end
        applyStimulus(1, 0, 9'h02A, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("clr2_done", init_done, 1);
        checkOutput("clr2_first_gnt0", gnt0, 1);
        checkOutput("clr2_first_addr", ram_address, 16'h002A);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("clr2_rvalid0", rvalid0, 1);
        checkOutput("clr2_rdata0", rdata0, 16'h0000);

        // Load rdata0 with a known value, then reset in the middle of a fill
        applyStimulus(1, 1, 9'h005, 16'hCAFE, 0, 0, 9'd0, 16'd0, 0);
        applyStimulus(1, 0, 9'h005, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("cafe_rdata0", rdata0, 16'hCAFE);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 1);
        for (int i = 0; i <= 300; i++) begin
            applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
            checkOutput("clr3_addr", ram_address, 16'(i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_load", ram_load, 0);
        checkOutput("arst_addr", ram_address, 16'h0000);
        checkOutput("arst_rdata0", rdata0, 16'h0000);
        checkOutput("arst_init_done", init_done, 0);
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            #1;
            checkOutput("clr4_addr", ram_address, 16'(i));
            checkOutput("clr4_load", ram_load, 1);
            checkOutput("clr4_init_done", init_done, 0);
        end
        applyStimulus(1, 0, 9'h005, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("clr4_done", init_done, 1);
        checkOutput("clr4_gnt0", gnt0, 1);
        applyStimulus(0, 0, 9'd0, 16'd0, 0, 0, 9'd0, 16'd0, 0);
        checkOutput("clr4_rvalid0", rvalid0, 1);
        checkOutput("clr4_rdata0", rdata0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
